// File: rtl/wm_pkg.sv
// Shared constants, FSM state type and mode encodings for the watermark engine.
package wm_pkg;

  localparam int unsigned PIX_W      = 12;
  localparam int unsigned CH_W       = 4;
  localparam int unsigned FRAME_SIZE = 4096;
  localparam int unsigned SIDE       = 64;

  localparam logic MODE_LSB = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRead,
    StWrite,
    StFinish
  } wm_state_e;

endpackage

// File: rtl/watermark_engine_if.sv
// Control and pixel-access signals between the engine and its display block.
interface watermark_engine_if;
  import wm_pkg::*;

  logic             start;
  logic             mode;
  logic [PIX_W-1:0] image_pix;
  logic [PIX_W-1:0] water_pix;
  logic [PIX_W-1:0] index;
  logic [PIX_W-1:0] regout;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, image_pix, water_pix,
    input  index, regout, busy, done
  );

  modport slave (
    input  start, mode, image_pix, water_pix,
    output index, regout, busy, done
  );

endinterface

// File: rtl/wm_pixel_blend.sv
// Combinational per-channel blend: LSB embed or 50/50 average of cover and watermark.
module wm_pixel_blend
  import wm_pkg::*;
#(
  parameter int unsigned EMBED_BITS = 1
) (
  input  logic [PIX_W-1:0] img,
  input  logic [PIX_W-1:0] wm,
  input  logic             mode,
  output logic [PIX_W-1:0] out
);

  localparam int unsigned NumCh = PIX_W / CH_W;
  localparam logic [CH_W-1:0] KeepMask = {CH_W{1'b1}} << EMBED_BITS;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [CH_W-1:0] i_ch;
    logic [CH_W-1:0] w_ch;
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] lsb_ch;

    assign i_ch   = img[c*CH_W +: CH_W];
    assign w_ch   = wm[c*CH_W +: CH_W];
    // Extra sum bit keeps the carry so the halved result never wraps.
    assign sum    = {1'b0, i_ch} + {1'b0, w_ch};
    assign lsb_ch = (i_ch & KeepMask) | (w_ch >> (CH_W - EMBED_BITS));

    assign out[c*CH_W +: CH_W] = (mode == MODE_AVG) ? sum[CH_W:1] : lsb_ch;
  end

endmodule

// File: rtl/watermark_engine.sv
// Walks the frame index space, blends each cover/watermark pixel pair and
// presents the result to the display block, one pass per start request.
module watermark_engine
  import wm_pkg::*;
#(
  parameter int unsigned SIZE       = FRAME_SIZE,
  parameter int unsigned EMBED_BITS = 1
) (
  input logic               CLK,
  input logic               RST_N,
  watermark_engine_if.slave bus
);

  localparam logic [PIX_W-1:0] LastIdx = PIX_W'(SIZE - 1);

  wm_state_e        state_q, state_d;
  logic [PIX_W-1:0] index_q, index_d;
  logic [PIX_W-1:0] regout_q, regout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic [PIX_W-1:0] blend;

  wm_pixel_blend #(
    .EMBED_BITS(EMBED_BITS)
  ) u_blend (
    .img (bus.image_pix),
    .wm  (bus.water_pix),
    .mode(mode_q),
    .out (blend)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    regout_d = regout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr:  state_d = StRead;
      StRead: begin
        regout_d = blend;
        state_d  = StWrite;
      end
      StWrite: begin
        if (index_q == LastIdx) begin
          state_d = StFinish;
        end else begin
          index_d = index_q + 12'd1;
          state_d = StAddr;
        end
      end
      StFinish: begin
        // busy/done are registered, so they change on the edge leaving FINISH.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      index_q  <= '0;
      regout_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= MODE_LSB;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      regout_q <= regout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.index  = index_q;
  assign bus.regout = regout_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_watermark_engine.sv
// Bench for watermark_engine: display-block model, vector table and pixel scoreboard.
module tb_watermark_engine;
  import wm_pkg::*;

  localparam int Size     = 4096;
  localparam int FrameCyc = 3 * Size + 1;

  typedef struct packed {
    logic [11:0] img;
    logic [11:0] wm;
    logic [11:0] lsb;
    logic [11:0] avg;
  } vec_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [11:0] pix;
  } sb_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  watermark_engine_if wif ();

  watermark_engine #(
    .SIZE      (Size),
    .EMBED_BITS(1)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (wif)
  );

  vec_t        tbl[8];
  sb_t         sb[$];
  logic [11:0] obuf[Size];
  int          vectors = 0;
  int          miscompares = 0;

  // Display block: registered pixel read, output buffer written every clock.
  always @(posedge CLK) begin
    wif.image_pix    <= tbl[wif.index[2:0]].img;
    wif.water_pix    <= tbl[wif.index[2:0]].wm;
    obuf[wif.index]  <= wif.regout;
  end

  function automatic logic [11:0] exp_pix(input int k, input bit m);
    return m ? tbl[k % 8].avg : tbl[k % 8].lsb;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input bit m, input bit disturb, input int rst_at);
    int busy_cyc = 0;
    int done_at  = -1;
    int bad      = 0;
    sb_t e;
    sb.delete();
    @(negedge CLK);
    wif.mode  = m;
    wif.start = 1'b1;
    @(posedge CLK);
    #1;
    wif.start = 1'b0;
    for (int n = 0; n < FrameCyc + 20; n++) begin
      if (n != 0) begin
        @(posedge CLK);
        #1;
      end
      if (disturb) begin
        wif.start = (n == 500 || n == 3 * Size);
        if (n == 600) wif.mode = ~m;
      end
      if (n == rst_at) begin
        chk("pre_rst_index", 32'(wif.index), 32'(rst_at / 3));
        RST_N = 1'b0;
        #1;
        chk("async_rst", 32'({wif.index, wif.regout, wif.busy, wif.done}), 32'd0);
        return;
      end
      if (n == 0) chk("busy_rise", 32'({wif.busy, wif.index}), 32'h1000);
      if (wif.busy) busy_cyc++;
      if (wif.done) begin
        done_at = n;
        break;
      end
      if (n % 3 == 0 && n < 3 * Size) sb.push_back('{idx: 32'(n / 3), pix: exp_pix(n / 3, m)});
      if (n % 3 == 2 && n < 3 * Size) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("write_index", 32'(wif.index), e.idx);
          chk("write_pixel", 32'(wif.regout), 32'(e.pix));
        end
      end
    end
    chk("done_at", 32'(done_at), 32'(FrameCyc));
    chk("busy_cycles", 32'(busy_cyc), 32'(FrameCyc));
    chk("busy_fall", 32'(wif.busy), 32'd0);
    chk("hold_index", 32'(wif.index), 32'(Size - 1));
    @(posedge CLK);
    #1;
    wif.start = 1'b0;
    chk("done_single", 32'({wif.busy, wif.done}), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < Size; i++) if (obuf[i] !== exp_pix(i, m)) bad++;
    chk("obuf_golden", 32'(bad), 32'd0);
  endtask

  initial begin
    tbl[0] = '{img: 12'hABC, wm: 12'h8F0, lsb: 12'hBBC, avg: 12'h9D6};
    tbl[1] = '{img: 12'hF00, wm: 12'h0F0, lsb: 12'hE10, avg: 12'h770};
    tbl[2] = '{img: 12'hFFF, wm: 12'hFFF, lsb: 12'hFFF, avg: 12'hFFF};
    tbl[3] = '{img: 12'h000, wm: 12'h000, lsb: 12'h000, avg: 12'h000};
    tbl[4] = '{img: 12'h123, wm: 12'h987, lsb: 12'h132, avg: 12'h555};
    tbl[5] = '{img: 12'h0EF, wm: 12'h7F1, lsb: 12'h0FE, avg: 12'h3E8};
    tbl[6] = '{img: 12'h800, wm: 12'h800, lsb: 12'h900, avg: 12'h800};
    tbl[7] = '{img: 12'h7E3, wm: 12'hC19, lsb: 12'h7E3, avg: 12'h976};
    wif.start = 1'b0;
    wif.mode  = 1'b0;
    RST_N     = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      chk("idle_after_reset", 32'({wif.index, wif.regout, wif.busy, wif.done}), 32'd0);
    end

    run_frame(MODE_LSB, 1'b0, -1);
    run_frame(MODE_AVG, 1'b0, -1);
    // Stray starts mid-frame and in FINISH, plus a mode flip that must not take effect.
    run_frame(MODE_LSB, 1'b1, -1);
    run_frame(MODE_AVG, 1'b0, 3 * 1000 + 1);
    @(posedge CLK);
    #1;
    chk("rst_held", 32'({wif.index, wif.regout, wif.busy, wif.done}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("no_resume", 32'(wif.busy), 32'd0);
    run_frame(MODE_AVG, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
